// File: rtl/wb_timer.sv
// Wishbone classic 64-bit machine timer (mtime/mtimecmp, CTRL, optional PRESCALE under WB_TIMER_PRESCALER_EN) driving timer_irq_o.
// Latency: one wait state; ack_o/err_o/dat_o registered, irq registered one cycle after mtime/mtimecmp.
// Backpressure: never stalls; one termination per strobe, a new strobe needs an idle sample in between.
module wb_timer #(
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic        timer_irq_o
);
    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;
`ifdef WB_TIMER_PRESCALER_EN
    localparam logic [2:0] OFF_PRESCALE    = 3'd5;
`endif

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic        req_q, req_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;
`ifdef WB_TIMER_PRESCALER_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] div_q, div_d;
`endif

    logic        req, accept, mapped, wr_en, tick;
    logic [2:0]  off;
    logic [31:0] rdata;
    logic        unused_adr;

    assign unused_adr = ^{adr_i[31:5], adr_i[1:0]};

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

    // Address decode and read mux
    always_comb begin
        off    = adr_i[4:2];
        req    = cyc_i & stb_i;
        // req_q is the previous request sample: only a rising strobe is accepted
        accept = req & ~req_q;
        mapped = 1'b0;
        rdata  = '0;
        case (off)
            OFF_MTIME_LO:    begin mapped = 1'b1; rdata = mtime_q[31:0];     end
            OFF_MTIME_HI:    begin mapped = 1'b1; rdata = mtime_q[63:32];    end
            OFF_MTIMECMP_LO: begin mapped = 1'b1; rdata = mtimecmp_q[31:0];  end
            OFF_MTIMECMP_HI: begin mapped = 1'b1; rdata = mtimecmp_q[63:32]; end
            OFF_CTRL:        begin mapped = 1'b1; rdata = {31'd0, en_q};     end
`ifdef WB_TIMER_PRESCALER_EN
            OFF_PRESCALE:    begin mapped = 1'b1; rdata = {16'd0, prescale_q}; end
`endif
            default:         begin mapped = 1'b0; rdata = '0;                end
        endcase
        wr_en = accept & we_i & mapped;
    end

    // Next-state: bus response, register writes, counter, compare
    always_comb begin
        req_d      = req;
        ack_d      = accept & mapped;
        err_d      = accept & ~mapped;
        dat_d      = (accept & mapped & ~we_i) ? rdata : 32'd0;
        irq_d      = (mtime_q >= mtimecmp_q);
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
`ifdef WB_TIMER_PRESCALER_EN
        prescale_d = prescale_q;
        tick       = en_q && (div_q == prescale_q);
        div_d      = (!en_q || tick || (wr_en && off == OFF_PRESCALE)) ? 16'd0 : div_q + 16'd1;
        if (wr_en && off == OFF_PRESCALE) begin
            if (sel_i[0]) prescale_d[7:0]  = dat_i[7:0];
            if (sel_i[1]) prescale_d[15:8] = dat_i[15:8];
        end
`else
        tick       = en_q;
`endif
        // A bus write to either mtime half suppresses the increment for that cycle
        if (wr_en && off == OFF_MTIME_LO) begin
            mtime_d[31:0] = lane_merge(mtime_q[31:0], dat_i, sel_i);
        end else if (wr_en && off == OFF_MTIME_HI) begin
            mtime_d[63:32] = lane_merge(mtime_q[63:32], dat_i, sel_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_en && off == OFF_MTIMECMP_LO) begin
            mtimecmp_d[31:0] = lane_merge(mtimecmp_q[31:0], dat_i, sel_i);
        end
        if (wr_en && off == OFF_MTIMECMP_HI) begin
            mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], dat_i, sel_i);
        end
        if (wr_en && off == OFF_CTRL && sel_i[0]) begin
            en_d = dat_i[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
            en_q       <= 1'b0;
            req_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
`ifdef WB_TIMER_PRESCALER_EN
            prescale_q <= '0;
            div_q      <= '0;
`endif
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            req_q      <= req_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
`ifdef WB_TIMER_PRESCALER_EN
            prescale_q <= prescale_d;
            div_q      <= div_d;
`endif
        end
    end

    assign dat_o       = dat_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rty_o       = 1'b0;
    assign timer_irq_o = irq_q;
endmodule
